dram_cache: RTL and testbench
=============================

# dram_cache

Direct-mapped, write-through, write-allocate word cache between `core` and `sdram_controller3`. It serves repeated core reads from on-chip storage, so a read hit does not pay the SDRAM access latency. Core-side ports use the same request/response protocol as the controller, so the block drops into the existing `dram_*` path unchanged.

## Interface
- `INDEX_BITS`, default 6: number of lines is 2^INDEX_BITS, each line one 32-bit word.
- `TAG_BITS`, default 24-INDEX_BITS: derived, not overridden.

Ports:
- `clk` in 1: system clock; the only clock in the block.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: invalidates all lines in one cycle.
- `cpu_addr` in 24: word address from the core.
- `cpu_data_in` in 32: write data from the core.
- `cpu_req_read` in 1: read request, level, held until `cpu_data_valid`.
- `cpu_req_write` in 1: write request, level, held until `cpu_write_complete`.
- `cpu_data_out` out 32: read data.
- `cpu_data_valid` out 1: one-cycle pulse, read done.
- `cpu_write_complete` out 1: one-cycle pulse, write done.
- `mem_addr` out 24: address to the controller.
- `mem_data_out` out 32: write data to the controller.
- `mem_req_read` out 1: read request to the controller, level.
- `mem_req_write` out 1: write request to the controller, level.
- `mem_data_in` in 32: read data from the controller.
- `mem_data_valid` in 1: controller read-done pulse.
- `mem_write_complete` in 1: controller write-done pulse.
- `hit_count` out 16: read-hit counter, wraps.
- `miss_count` out 16: read-miss counter, wraps.

## Operation
- Address split: index = `cpu_addr[INDEX_BITS-1:0]`, tag = `cpu_addr[23:INDEX_BITS]`.
- Storage:
  - valid bits in flops, cleared in a single cycle;
  - tag and data arrays with registered read.
- All outputs are registered.
- States: IDLE, LOOKUP, MISS_RD, WR_MEM, DONE.
- IDLE
  - `cpu_req_write`: latch addr/data, drive `mem_addr`/`mem_data_out`, assert `mem_req_write`, go to WR_MEM.
  - else `cpu_req_read`: latch addr, issue array read, go to LOOKUP.
  - Write wins if both requests are high.
- LOOKUP
  - Hit (valid and tag equal): `cpu_data_out` = array data, `cpu_data_valid` = 1, `hit_count`+1, go to DONE.
  - Miss: `mem_addr` = latched addr, assert `mem_req_read`, `miss_count`+1, go to MISS_RD.
- MISS_RD
  - Hold `mem_req_read` until `mem_data_valid` is sampled high.
  - On that edge:
    - clear `mem_req_read`;
    - write the line (valid = 1, tag, data = `mem_data_in`);
    - `cpu_data_out` = `mem_data_in`, `cpu_data_valid` = 1;
    - go to DONE.
- WR_MEM
  - Hold `mem_req_write` until `mem_write_complete`.
  - On that edge:
    - clear `mem_req_write`;
    - write the line (valid = 1, tag, data = latched write data), replacing any prior tag;
    - `cpu_write_complete` = 1;
    - go to DONE.
- DONE
  - The response pulse is visible during this cycle.
  - Requests are ignored; next state is IDLE.
  - Pulses return to 0.
- `flush`
  - Clears all valid bits on any edge.
  - If a line fill occurs on the same edge, flush wins and the line ends invalid.
  - Does not abort an in-flight access.
- `rst`
  - Next edge: state IDLE, all valid bits 0, counters 0.
  - Every output 0: `cpu_data_out`, `cpu_data_valid`, `cpu_write_complete`, `mem_addr`, `mem_data_out`, `mem_req_read`, `mem_req_write`.
  - Applies mid-transaction too; the pending controller response is then ignored, since the block is IDLE and not waiting on it.
- Responses from the controller arriving outside MISS_RD/WR_MEM are ignored.

## Timing
- Request sampled at edge E0 in IDLE.
- Read hit: `cpu_data_valid` is high in the cycle after E1, i.e. 2 cycles after sampling.
- Read miss: `mem_req_read` rises after E1; `cpu_data_valid` is high the cycle after the cycle in which `mem_data_valid` is high.
- Write: `mem_req_write` rises after E0; `cpu_write_complete` is high the cycle after `mem_write_complete`.
- Core obligation: drop its request by the edge ending the pulse cycle. A request still high in the following IDLE cycle is treated as new.
- Minimum back-to-back spacing: a hit read is 3 cycles from sample to next sample.
- `mem_req_*` is never high for two transactions without an intervening low cycle.

## Test plan
- After reset:
  - read 0x000040 with the model returning 0xDEADBEEF;
  - -> `mem_req_read` pulse train, `cpu_data_valid` with 0xDEADBEEF, `miss_count`=1;
  - re-read -> data 2 cycles after sampling, no `mem_req_read`, `hit_count`=1.
- Conflict miss (INDEX_BITS=6):
  - read 0x000040, then 0x000080 (same index, different tag), then 0x000040;
  - -> three misses, `miss_count`=3, `hit_count`=0.
- Write-through:
  - write 0x000123 = 0x12345678 -> `mem_req_write` with that addr/data, `cpu_write_complete` one cycle after `mem_write_complete`;
  - then read 0x000123 -> hit returning 0x12345678.
- Flush:
  - load 0x000010 (miss then hit), assert `flush` for 1 cycle;
  - read 0x000010 -> miss, controller read issued.
- Reset mid-miss:
  - assert `rst` while in MISS_RD -> next cycle all outputs 0;
  - a late `mem_data_valid` produces no `cpu_data_valid`;
  - a subsequent read of the same addr misses.
- Simultaneous `cpu_req_read`/`cpu_req_write` at 0x000200 -> write serviced first, `mem_req_write` asserted, `mem_req_read` stays 0.

Source files
------------

// File: rtl/dram_cache.sv
// dram_cache: direct-mapped, write-through, write-allocate word cache that sits
// between the core and the SDRAM controller. Core side and memory side use the
// same level-request / pulse-response protocol, so it is transparent on the path.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 invalidates every line in one cycle
//   cpu_addr/cpu_data_in  core word address / write data
//   cpu_req_read/_write   core requests (level, held until the response pulse)
//   cpu_data_out          read data (registered)
//   cpu_data_valid        one-cycle read-done pulse
//   cpu_write_complete    one-cycle write-done pulse
//   mem_addr/mem_data_out controller address / write data
//   mem_req_read/_write   controller requests (level)
//   mem_data_in           controller read data
//   mem_data_valid        controller read-done pulse
//   mem_write_complete    controller write-done pulse
//   hit_count/miss_count  wrapping read-hit / read-miss counters
module dram_cache #(
   parameter int unsigned INDEX_BITS = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [23:0] cpu_addr,
   input  logic [31:0] cpu_data_in,
   input  logic        cpu_req_read,
   input  logic        cpu_req_write,
   output logic [31:0] cpu_data_out,
   output logic        cpu_data_valid,
   output logic        cpu_write_complete,
   output logic [23:0] mem_addr,
   output logic [31:0] mem_data_out,
   output logic        mem_req_read,
   output logic        mem_req_write,
   input  logic [31:0] mem_data_in,
   input  logic        mem_data_valid,
   input  logic        mem_write_complete,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
);

   localparam int unsigned TAG_BITS = 24 - INDEX_BITS;
   localparam int unsigned Lines    = 1 << INDEX_BITS;

   typedef enum logic [2:0] {StIdle, StLookup, StMissRd, StWrMem, StDone} state_e;

   state_e                state_q, state_d;
   logic [23:0]           addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [Lines-1:0]      valid_q, valid_d;
   logic [31:0]           cpu_data_out_q, cpu_data_out_d;
   logic                  cpu_data_valid_q, cpu_data_valid_d;
   logic                  cpu_write_complete_q, cpu_write_complete_d;
   logic [23:0]           mem_addr_q, mem_addr_d;
   logic [31:0]           mem_data_out_q, mem_data_out_d;
   logic                  mem_req_read_q, mem_req_read_d;
   logic                  mem_req_write_q, mem_req_write_d;
   logic [15:0]           hit_q, hit_d;
   logic [15:0]           miss_q, miss_d;

   // Tag/data arrays: plain memories with a registered read port, no reset.
   logic [TAG_BITS-1:0]   tag_mem [Lines];
   logic [31:0]           data_mem [Lines];
   logic [TAG_BITS-1:0]   tag_rd_q;
   logic [31:0]           data_rd_q;
   logic                  arr_re, arr_we;
   logic [31:0]           arr_wdata;

   logic [INDEX_BITS-1:0] idx_q, rd_idx;
   logic [TAG_BITS-1:0]   tag_q;
   logic                  lookup_hit;

   assign idx_q      = addr_q[INDEX_BITS-1:0];
   assign tag_q      = addr_q[23:INDEX_BITS];
   assign rd_idx     = cpu_addr[INDEX_BITS-1:0];
   assign lookup_hit = valid_q[idx_q] && (tag_rd_q == tag_q);

   always_comb begin
      state_d              = state_q;
      addr_d               = addr_q;
      wdata_d              = wdata_q;
      cpu_data_out_d       = cpu_data_out_q;
      cpu_data_valid_d     = 1'b0;
      cpu_write_complete_d = 1'b0;
      mem_addr_d           = mem_addr_q;
      mem_data_out_d       = mem_data_out_q;
      mem_req_read_d       = mem_req_read_q;
      mem_req_write_d      = mem_req_write_q;
      hit_d                = hit_q;
      miss_d               = miss_q;
      arr_re               = 1'b0;
      arr_we               = 1'b0;
      arr_wdata            = wdata_q;

      unique case (state_q)
         StIdle: begin
            // Write has priority over a simultaneous read.
            if (cpu_req_write) begin
               addr_d          = cpu_addr;
               wdata_d         = cpu_data_in;
               mem_addr_d      = cpu_addr;
               mem_data_out_d  = cpu_data_in;
               mem_req_write_d = 1'b1;
               state_d         = StWrMem;
            end else if (cpu_req_read) begin
               addr_d  = cpu_addr;
               arr_re  = 1'b1;
               state_d = StLookup;
            end
         end
         StLookup: begin
            if (lookup_hit) begin
               cpu_data_out_d   = data_rd_q;
               cpu_data_valid_d = 1'b1;
               hit_d            = hit_q + 16'd1;
               state_d          = StDone;
            end else begin
               mem_addr_d     = addr_q;
               mem_req_read_d = 1'b1;
               miss_d         = miss_q + 16'd1;
               state_d        = StMissRd;
            end
         end
         StMissRd: begin
            if (mem_data_valid) begin
               mem_req_read_d   = 1'b0;
               arr_we           = 1'b1;
               arr_wdata        = mem_data_in;
               cpu_data_out_d   = mem_data_in;
               cpu_data_valid_d = 1'b1;
               state_d          = StDone;
            end
         end
         StWrMem: begin
            if (mem_write_complete) begin
               mem_req_write_d      = 1'b0;
               arr_we               = 1'b1;
               arr_wdata            = wdata_q;
               cpu_write_complete_d = 1'b1;
               state_d              = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      valid_d = valid_q;
      if (arr_we) begin
         valid_d[idx_q] = 1'b1;
      end
      // A flush on the same edge as a fill leaves the line invalid.
      if (flush) begin
         valid_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q              <= StIdle;
         addr_q               <= '0;
         wdata_q              <= '0;
         valid_q              <= '0;
         cpu_data_out_q       <= '0;
         cpu_data_valid_q     <= 1'b0;
         cpu_write_complete_q <= 1'b0;
         mem_addr_q           <= '0;
         mem_data_out_q       <= '0;
         mem_req_read_q       <= 1'b0;
         mem_req_write_q      <= 1'b0;
         hit_q                <= '0;
         miss_q               <= '0;
      end else begin
         state_q              <= state_d;
         addr_q               <= addr_d;
         wdata_q              <= wdata_d;
         valid_q              <= valid_d;
         cpu_data_out_q       <= cpu_data_out_d;
         cpu_data_valid_q     <= cpu_data_valid_d;
         cpu_write_complete_q <= cpu_write_complete_d;
         mem_addr_q           <= mem_addr_d;
         mem_data_out_q       <= mem_data_out_d;
         mem_req_read_q       <= mem_req_read_d;
         mem_req_write_q      <= mem_req_write_d;
         hit_q                <= hit_d;
         miss_q               <= miss_d;
      end
   end

   always_ff @(posedge clk) begin
      if (arr_we) begin
         tag_mem[idx_q]  <= tag_q;
         data_mem[idx_q] <= arr_wdata;
      end
      if (arr_re) begin
         tag_rd_q  <= tag_mem[rd_idx];
         data_rd_q <= data_mem[rd_idx];
      end
   end

   assign cpu_data_out       = cpu_data_out_q;
   assign cpu_data_valid     = cpu_data_valid_q;
   assign cpu_write_complete = cpu_write_complete_q;
   assign mem_addr           = mem_addr_q;
   assign mem_data_out       = mem_data_out_q;
   assign mem_req_read       = mem_req_read_q;
   assign mem_req_write      = mem_req_write_q;
   assign hit_count          = hit_q;
   assign miss_count         = miss_q;

endmodule

// File: tb/tb_dram_cache.sv
// tb_dram_cache: self-checking bench for dram_cache. Directed scenarios plus a
// randomized run, checked against a line-level cache model and a word memory model.
module tb_dram_cache;

   localparam int IB    = 6;
   localparam int Lines = 1 << IB;

   logic        clk = 1'b0;
   logic        rst, flush;
   logic [23:0] cpu_addr;
   logic [31:0] cpu_data_in;
   logic        cpu_req_read, cpu_req_write;
   logic [31:0] cpu_data_out;
   logic        cpu_data_valid, cpu_write_complete;
   logic [23:0] mem_addr;
   logic [31:0] mem_data_out;
   logic        mem_req_read, mem_req_write;
   logic [31:0] mem_data_in;
   logic        mem_data_valid, mem_write_complete;
   logic [15:0] hit_count, miss_count;

   always #5 clk = ~clk;

   dram_cache #(.INDEX_BITS(IB)) dut (
      .clk                (clk),
      .rst                (rst),
      .flush              (flush),
      .cpu_addr           (cpu_addr),
      .cpu_data_in        (cpu_data_in),
      .cpu_req_read       (cpu_req_read),
      .cpu_req_write      (cpu_req_write),
      .cpu_data_out       (cpu_data_out),
      .cpu_data_valid     (cpu_data_valid),
      .cpu_write_complete (cpu_write_complete),
      .mem_addr           (mem_addr),
      .mem_data_out       (mem_data_out),
      .mem_req_read       (mem_req_read),
      .mem_req_write      (mem_req_write),
      .mem_data_in        (mem_data_in),
      .mem_data_valid     (mem_data_valid),
      .mem_write_complete (mem_write_complete),
      .hit_count          (hit_count),
      .miss_count         (miss_count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: backing memory plus which address each line holds.
   logic [31:0] mem_model [logic [23:0]];
   bit          cv [Lines];
   logic [23:0] caddr [Lines];
   int unsigned exp_hits, exp_misses;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [23:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return {8'hA5, a};
   endfunction

   task automatic model_reset();
      foreach (cv[i]) cv[i] = 1'b0;
      exp_hits   = 0;
      exp_misses = 0;
   endtask

   task automatic check_all_zero(input string pfx);
      check_eq({pfx, "_cpu_data_out"}, cpu_data_out, 32'h0);
      check_eq({pfx, "_cpu_data_valid"}, 32'(cpu_data_valid), 32'h0);
      check_eq({pfx, "_cpu_write_complete"}, 32'(cpu_write_complete), 32'h0);
      check_eq({pfx, "_mem_addr"}, 32'(mem_addr), 32'h0);
      check_eq({pfx, "_mem_data_out"}, mem_data_out, 32'h0);
      check_eq({pfx, "_mem_req_rw"}, 32'({mem_req_read, mem_req_write}), 32'h0);
      check_eq({pfx, "_counters"}, {hit_count, miss_count}, 32'h0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      cpu_req_read = 1'b0;
      cpu_req_write = 1'b0;
      mem_data_valid = 1'b0;
      mem_write_complete = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      check_all_zero("rst");
      rst = 1'b0;
      model_reset();
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   task automatic do_read(input logic [23:0] a);
      int          idx   = int'(a[IB-1:0]);
      bit          hit   = cv[idx] && (caddr[idx] == a);
      logic [31:0] exp_d = mem_rd(a);
      int          lat   = int'($urandom_range(0, 3));
      int          wcnt  = 0;
      int          n     = 0;
      int          resp_n = -10;
      bit          saw_rd = 1'b0;
      bit          done   = 1'b0;
      cpu_addr     = a;
      cpu_req_read = 1'b1;
      while (!done && n < 100) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         mem_data_valid = 1'b0;
         if (cpu_data_valid) begin
            check_eq("rd_data", cpu_data_out, exp_d);
            if (hit) check_eq("rd_hit_latency", 32'(n), 32'd2);
            else     check_eq("rd_miss_latency", 32'(n), 32'(resp_n + 1));
            check_eq("rd_req_dropped", 32'(mem_req_read), 32'h0);
            done = 1'b1;
            cpu_req_read = 1'b0;
         end else if (mem_req_read && resp_n < 0) begin
            if (!saw_rd) begin
               saw_rd = 1'b1;
               check_eq("rd_mem_addr", 32'(mem_addr), 32'(a));
            end
            if (wcnt == lat) begin
               mem_data_in    = exp_d;
               mem_data_valid = 1'b1;
               resp_n         = n;
            end else begin
               wcnt++;
            end
         end
      end
      if (!done) begin
         check_eq("rd_timeout", 32'h0, 32'h1);
         cpu_req_read = 1'b0;
      end
      check_eq("rd_mem_issued", 32'(saw_rd), 32'(!hit));
      if (hit) exp_hits++;
      else begin
         exp_misses++;
         cv[idx]    = 1'b1;
         caddr[idx] = a;
      end
      check_eq("hit_count", 32'(hit_count), 32'(exp_hits[15:0]));
      check_eq("miss_count", 32'(miss_count), 32'(exp_misses[15:0]));
      @(negedge clk);
      check_eq("rd_pulse_low", 32'(cpu_data_valid), 32'h0);
   endtask

   task automatic do_write(input logic [23:0] a, input logic [31:0] d, input bit both);
      int idx    = int'(a[IB-1:0]);
      int lat    = int'($urandom_range(0, 3));
      int wcnt   = 0;
      int n      = 0;
      int resp_n = -10;
      bit saw_rd = 1'b0;
      bit saw_wr = 1'b0;
      bit done   = 1'b0;
      cpu_addr      = a;
      cpu_data_in   = d;
      cpu_req_write = 1'b1;
      cpu_req_read  = both;
      while (!done && n < 100) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         mem_write_complete = 1'b0;
         if (mem_req_read) saw_rd = 1'b1;
         if (cpu_write_complete) begin
            check_eq("wr_latency", 32'(n), 32'(resp_n + 1));
            check_eq("wr_req_dropped", 32'(mem_req_write), 32'h0);
            done = 1'b1;
            cpu_req_write = 1'b0;
            cpu_req_read  = 1'b0;
         end else if (mem_req_write && resp_n < 0) begin
            if (!saw_wr) begin
               saw_wr = 1'b1;
               check_eq("wr_req_rise", 32'(n), 32'd1);
               check_eq("wr_mem_addr", 32'(mem_addr), 32'(a));
               check_eq("wr_mem_data", mem_data_out, d);
            end
            if (wcnt == lat) begin
               mem_write_complete = 1'b1;
               resp_n = n;
            end else begin
               wcnt++;
            end
         end
      end
      if (!done) begin
         check_eq("wr_timeout", 32'h0, 32'h1);
         cpu_req_write = 1'b0;
         cpu_req_read  = 1'b0;
      end
      check_eq("wr_no_mem_read", 32'(saw_rd), 32'h0);
      mem_model[a] = d;
      cv[idx]      = 1'b1;
      caddr[idx]   = a;
      check_eq("wr_counters", {hit_count, miss_count},
               {exp_hits[15:0], exp_misses[15:0]});
      @(negedge clk);
      check_eq("wr_pulse_low", 32'(cpu_write_complete), 32'h0);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      foreach (cv[i]) cv[i] = 1'b0;
   endtask

   task automatic reset_mid_miss(input logic [23:0] a);
      int n = 0;
      cpu_addr     = a;
      cpu_req_read = 1'b1;
      while (!mem_req_read && n < 20) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      check_eq("mid_miss_reached", 32'(mem_req_read), 32'h1);
      rst = 1'b1;
      cpu_req_read = 1'b0;
      @(negedge clk);
      check_all_zero("mid_rst");
      rst = 1'b0;
      model_reset();
      mem_data_in    = 32'h0BAD0BAD;
      mem_data_valid = 1'b1;
      @(negedge clk);
      mem_data_valid = 1'b0;
      check_eq("late_resp_ignored", 32'({cpu_data_valid, mem_req_read}), 32'h0);
      @(negedge clk);
      check_eq("late_resp_ignored2", 32'({cpu_data_valid, mem_req_read}), 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      cpu_addr = '0;
      cpu_data_in = '0;
      cpu_req_read = 1'b0;
      cpu_req_write = 1'b0;
      mem_data_in = '0;
      mem_data_valid = 1'b0;
      mem_write_complete = 1'b0;
      model_reset();
      apply_reset();

      mem_model[24'h000040] = 32'hDEADBEEF;
      do_read(24'h000040);
      do_read(24'h000040);

      // Conflict misses on index 0.
      apply_reset();
      do_read(24'h000040);
      do_read(24'h000080);
      do_read(24'h000040);
      check_eq("conflict_counts", {hit_count, miss_count}, {16'd0, 16'd3});

      do_write(24'h000123, 32'h12345678, 1'b0);
      do_read(24'h000123);

      do_read(24'h000010);
      do_read(24'h000010);
      do_flush();
      do_read(24'h000010);

      reset_mid_miss(24'h000300);
      do_read(24'h000300);

      do_write(24'h000200, 32'hCAFEF00D, 1'b1);
      do_read(24'h000200);

      for (int i = 0; i < 200; i++) begin
         int unsigned r = $urandom_range(0, 19);
         logic [23:0] a;
         a = 24'(($urandom_range(0, 3) << IB) | $urandom_range(0, 7));
         if (r < 13)      do_read(a);
         else if (r < 19) do_write(a, $urandom, ($urandom_range(0, 3) == 0));
         else             do_flush();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
